fetch_insn_queue: RTL and testbench
===================================

// Module: fetch_insn_queue
// PURPOSE
// Downstream of the fetch bus interface. Accepts 64-bit instruction beats from the Sysbus
// response channel and acks them. Buffers the beats with their PCs, then presents one
// 32-bit instruction per cycle to decode over a valid/ready handshake.
// Supports redirect (branch/entry load): flushes buffered state, discards the rest of the
// in-flight line, and restarts at the new PC.
// PARAMETERS
// BUS_DATA_WIDTH  64  response beat width; fixed at 64 (two 32-bit insns per beat)
// BUS_TAG_WIDTH   13  response tag width; tag is ignored by this block
// DEPTH           8   queue entries (64-bit beat + 64-bit beat PC); power of two
// BEATS_PER_LINE  8   beats per 64-byte line returned by the bus
// PORTS
// clk           in   1    clock, rising edge
// reset         in   1    asynchronous, active-low reset
// bus_respcyc   in   1    response beat valid
// bus_resp      in   64   response beat; [31:0] = insn at beat PC, [63:32] = beat PC + 4
// bus_resptag   in   13   response tag (unused)
// bus_respack   out  1    beat accepted this cycle
// redirect      in   1    one-cycle pulse: restart fetch at redirect_pc
// redirect_pc   in   64   new PC; [1:0] ignored
// insn_valid    out  1    insn/insn_pc valid
// insn          out  32   instruction word
// insn_pc       out  64   PC of insn
// insn_ready    in   1    decode consumes insn this cycle
// BEHAVIOUR
// - Reset (async, reset=0): count=0, rd/wr ptr=0, half=0, beat_idx=0, drop_cnt=0,
//   beat_pc=0, skip_low=0. Outputs: insn_valid=0, bus_respack=0, insn=0, insn_pc=0.
//   Upstream pulses redirect with the entry PC after reset. Reset mid-line drops all state.
// - bus_respack (combinational) = bus_respcyc & reset & !redirect & (drop_cnt!=0 | count<DEPTH).
//   A beat is accepted when bus_respcyc & bus_respack.
// - Accept with drop_cnt!=0: beat discarded, drop_cnt--. Queue untouched.
// - Accept with drop_cnt==0: push {bus_resp, beat_pc}; beat_pc += 8;
//   beat_idx = (beat_idx+1) mod BEATS_PER_LINE.
// - Full (count==DEPTH): respack=0 even if a pop happens that cycle (no bypass).
// - Latency: beat accepted in cycle N -> insn_valid earliest in cycle N+1 (registered queue).
// - Output: insn_valid = count!=0. Head beat H:
//   insn = half ? H.data[63:32] : H.data[31:0]; insn_pc = H.pc + (half ? 4 : 0).
// - Pop: on insn_valid & insn_ready with half=0 -> half=1. With half=1 -> pop head, half=0.
//   A simultaneous push and pop is legal when count<DEPTH; count is unchanged.
// - Ptr and beat_pc arithmetic: modulo DEPTH and modulo 2^64 respectively (wrap silently).
// - Redirect (highest priority over push and pop that cycle):
//   - count=0, rd=wr, half=0.
//   - beat_pc = {redirect_pc[63:3], 3'b0}; skip_low = redirect_pc[2].
//   - drop_cnt = (beat_idx==0) ? 0 : BEATS_PER_LINE - beat_idx; beat_idx = 0.
//   - Any beat presented in the redirect cycle is not acked.
//   - Upstream must not redirect between issuing a line request and its first beat.
// - skip_low: first beat pushed after a redirect sets half=1 on entry (low insn skipped),
//   then skip_low clears.
// - Redirect while drop_cnt!=0: drop_cnt is recomputed from beat_idx (already 0),
//   giving 0, so in-flight drops are lost. Upstream must not redirect twice within one line.
// TESTING
// - Redirect 0x1000, 8 beats with data {i*2+1, i*2}, ready=1 -> 16 insns 0..15 in order,
//   pc 0x1000..0x103C step 4.
// - Redirect 0x1004, 8 beats -> first insn = beat0[63:32] at pc 0x1004; 15 insns total.
// - ready=0, respcyc held high -> exactly 8 beats acked, respack low on 9th;
//   one ready pulse pair frees a slot.
// - Redirect 0x2000 after 3 beats of a line -> next 5 beats acked and dropped; following
//   line's beat0 -> insn_pc 0x2000.
// - Redirect and bus_respcyc in same cycle -> respack=0, count=0 next cycle, insn_valid=0.
// - Assert reset mid-stream with count=5 -> insn_valid and bus_respack fall immediately;
//   after release count=0.

Source files
------------

// File: rtl/fetch_insn_queue.sv
// fetch_insn_queue: buffers 64-bit instruction beats from the Sysbus response
// channel together with their PCs and hands decode one 32-bit instruction per
// cycle over a valid/ready handshake. A redirect flushes the queue, discards the
// remainder of the in-flight line and restarts at the new PC.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus_respcyc  response beat valid
//   bus_resp     response beat: [31:0] insn at beat PC, [63:32] insn at beat PC + 4
//   bus_resptag  response tag (not used by this block)
//   bus_respack  beat accepted this cycle (combinational)
//   redirect     one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc  new PC, [1:0] ignored
//   insn_valid   insn / insn_pc valid
//   insn         instruction word
//   insn_pc      PC of insn
//   insn_ready   decode consumes insn this cycle
`timescale 1ns/1ps
module fetch_insn_queue #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned BEATS_PER_LINE = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc,
  output logic                      insn_valid,
  output logic [31:0]               insn,
  output logic [63:0]               insn_pc,
  input  logic                      insn_ready
);

  localparam int unsigned PC_W  = 64;
  localparam int unsigned INS_W = 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(BEATS_PER_LINE);
  localparam int unsigned DRP_W = IDX_W + 1;

  logic [BUS_DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PC_W-1:0]           mem_pc   [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             half;
  logic [IDX_W-1:0] beat_idx;
  logic [DRP_W-1:0] drop_cnt;
  logic [PC_W-1:0]  beat_pc;
  logic             skip_low;

  logic accept_c, push_c, drop_c, fire_c, pop_c;

  // Tag and the two low PC bits carry no information for this block.
  logic unused_ok;
  assign unused_ok = ^{bus_resptag, redirect_pc[1:0]};

  // Ack while dropping the tail of an abandoned line, or while there is room.
  // No bypass: a pop in the same cycle does not make room for a full queue.
  assign bus_respack = bus_respcyc & reset & ~redirect &
                       ((drop_cnt != '0) | (count < CNT_W'(DEPTH)));
  assign accept_c    = bus_respcyc & bus_respack;
  assign drop_c      = accept_c & (drop_cnt != '0);
  assign push_c      = accept_c & (drop_cnt == '0);
  assign fire_c      = insn_valid & insn_ready;
  assign pop_c       = fire_c & half;

  // Head-of-queue presentation; zero when empty so outputs are clean after reset.
  always_comb begin
    insn_valid = (count != '0);
    insn       = '0;
    insn_pc    = '0;
    if (insn_valid) begin
      insn    = half ? mem_data[rd_ptr][2*INS_W-1:INS_W] : mem_data[rd_ptr][INS_W-1:0];
      insn_pc = mem_pc[rd_ptr] + (half ? PC_W'(4) : PC_W'(0));
    end
  end

  // Beat storage.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_data[wr_ptr] <= bus_resp;
      mem_pc[wr_ptr]   <= beat_pc;
    end
  end

  // Queue control, line tracking and redirect handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      half     <= 1'b0;
      beat_idx <= '0;
      drop_cnt <= '0;
      beat_pc  <= '0;
      skip_low <= 1'b0;
    end else if (redirect) begin
      rd_ptr   <= wr_ptr;
      count    <= '0;
      half     <= 1'b0;
      beat_pc  <= {redirect_pc[PC_W-1:3], 3'b000};
      skip_low <= redirect_pc[2];
      // Beats still owed by the bus for the current line must be swallowed.
      drop_cnt <= (beat_idx == '0) ? '0 : DRP_W'(BEATS_PER_LINE) - DRP_W'(beat_idx);
      beat_idx <= '0;
    end else begin
      if (drop_c) begin
        drop_cnt <= drop_cnt - DRP_W'(1);
      end
      if (push_c) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        beat_pc  <= beat_pc + PC_W'(8);
        beat_idx <= (beat_idx == IDX_W'(BEATS_PER_LINE - 1)) ? '0 : beat_idx + IDX_W'(1);
        skip_low <= 1'b0;
      end
      // First beat after a word-4 redirect enters an empty queue with its low insn skipped.
      if (push_c && skip_low) begin
        half <= 1'b1;
      end else if (fire_c) begin
        half <= ~half;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

endmodule

// File: tb/tb_fetch_insn_queue.sv
`timescale 1ns/1ps
module tb_fetch_insn_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        insn_valid;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        insn_ready;

  int checks = 0;
  int errors = 0;

  fetch_insn_queue dut (
    .clk         (clk),
    .reset       (reset),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .insn_valid  (insn_valid),
    .insn        (insn),
    .insn_pc     (insn_pc),
    .insn_ready  (insn_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        cyc;
    logic [63:0] resp;
    logic        rdy;
    logic        e_ack;
    logic        e_valid;
    logic [31:0] e_insn;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic redir, input logic [63:0] rpc, input logic cyc,
                              input logic [63:0] resp, input logic rdy, input logic e_ack,
                              input logic e_valid, input logic [31:0] e_insn,
                              input logic [63:0] e_pc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.cyc = cyc; v.resp = resp; v.rdy = rdy;
    v.e_ack = e_ack; v.e_valid = e_valid; v.e_insn = e_insn; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Redirect to rpc, stream one full line with data {2i+1,2i}, ready held high.
  task automatic stream_line(input logic [63:0] rpc, input string tag);
    int sent = 0;
    int idx;
    logic [63:0] base;
    base = {rpc[63:3], 3'b000};
    idx  = rpc[2] ? 1 : 0;
    redirect = 1'b1; redirect_pc = rpc; bus_respcyc = 1'b0; insn_ready = 1'b1;
    @(negedge clk);
    chk({tag, " redirect ack"}, 64'(bus_respack), 64'd0);
    next_cycle();
    redirect = 1'b0;
    for (int cyc = 0; cyc < 60 && idx < 16; cyc++) begin
      bus_respcyc = (sent < 8);
      bus_resp    = {32'(2*sent + 1), 32'(2*sent)};
      @(negedge clk);
      if (bus_respcyc) begin
        chk($sformatf("%s beat%0d ack", tag, sent), 64'(bus_respack), 64'd1);
        if (bus_respack) sent++;
      end
      if (insn_valid) begin
        chk($sformatf("%s insn%0d", tag, idx), 64'(insn), 64'(idx));
        chk($sformatf("%s pc%0d", tag, idx), insn_pc, base + 64'(4*idx));
        idx++;
      end
      next_cycle();
    end
    bus_respcyc = 1'b0;
    chk({tag, " insns delivered"}, 64'(idx), 64'd16);
  endtask

  initial begin
    int acc;
    reset = 1'b0; bus_respcyc = 1'b1; bus_resp = '0; bus_resptag = '0;
    redirect = 1'b0; redirect_pc = '0; insn_ready = 1'b0;

    // Reset state, with a beat offered: must not be acked.
    #2;
    chk("reset ack", 64'(bus_respack), 64'd0);
    chk("reset valid", 64'(insn_valid), 64'd0);
    chk("reset insn", 64'(insn), 64'd0);
    chk("reset pc", insn_pc, 64'd0);
    @(negedge clk);
    bus_respcyc = 1'b0; reset = 1'b1;
    next_cycle();

    stream_line(64'h1000, "line1000");
    stream_line(64'h1004, "line1004");

    // Full queue: ready low, beats offered continuously.
    redirect = 1'b1; redirect_pc = 64'h3000; insn_ready = 1'b0;
    next_cycle();
    redirect = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus_respcyc = 1'b1;
      bus_resp    = {32'(2*acc + 1), 32'(2*acc)};
      @(negedge clk);
      chk($sformatf("full cyc%0d ack", c), 64'(bus_respack), (c < 8) ? 64'd1 : 64'd0);
      if (bus_respack) acc++;
      next_cycle();
    end
    insn_ready = 1'b1;
    @(negedge clk);
    chk("full pop1 ack", 64'(bus_respack), 64'd0);
    chk("full pop1 insn", 64'(insn), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("full pop2 ack", 64'(bus_respack), 64'd0);
    chk("full pop2 insn", 64'(insn), 64'd1);
    next_cycle();
    insn_ready = 1'b0;
    @(negedge clk);
    chk("full freed ack", 64'(bus_respack), 64'd1);
    next_cycle();
    bus_respcyc = 1'b0; insn_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("drain insn%0d", k + 2), 64'(insn), 64'(k + 2));
      chk($sformatf("drain pc%0d", k + 2), insn_pc, 64'h3008 + 64'(4*k));
      next_cycle();
    end
    insn_ready = 1'b0;
    @(negedge clk);
    chk("five left valid", 64'(insn_valid), 64'd1);
    chk("five left insn", 64'(insn), 64'd8);
    chk("five left pc", insn_pc, 64'h3020);

    // Reset mid-stream: outputs fall without waiting for a clock.
    next_cycle();
    bus_respcyc = 1'b1;
    reset = 1'b0;
    #1;
    chk("midreset valid", 64'(insn_valid), 64'd0);
    chk("midreset ack", 64'(bus_respack), 64'd0);
    chk("midreset insn", 64'(insn), 64'd0);
    @(negedge clk);
    bus_respcyc = 1'b0; reset = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("postreset valid", 64'(insn_valid), 64'd0);
    next_cycle();

    // Short line, drain, mid-line redirect with drops, then redirect+beat collision.
    tbl[0]  = mk(1, 64'h1000, 0, 64'h0,                    1, 0, 0, 32'h0,  64'h0);
    tbl[1]  = mk(0, 64'h0,    1, {32'h1, 32'h0},           1, 1, 0, 32'h0,  64'h0);
    tbl[2]  = mk(0, 64'h0,    1, {32'h3, 32'h2},           1, 1, 1, 32'h0,  64'h1000);
    tbl[3]  = mk(0, 64'h0,    1, {32'h5, 32'h4},           1, 1, 1, 32'h1,  64'h1004);
    tbl[4]  = mk(0, 64'h0,    0, 64'h0,                    1, 0, 1, 32'h2,  64'h1008);
    tbl[5]  = mk(0, 64'h0,    0, 64'h0,                    1, 0, 1, 32'h3,  64'h100C);
    tbl[6]  = mk(0, 64'h0,    0, 64'h0,                    1, 0, 1, 32'h4,  64'h1010);
    tbl[7]  = mk(0, 64'h0,    0, 64'h0,                    1, 0, 1, 32'h5,  64'h1014);
    tbl[8]  = mk(0, 64'h0,    0, 64'h0,                    1, 0, 0, 32'h0,  64'h0);
    tbl[9]  = mk(1, 64'h2000, 0, 64'h0,                    1, 0, 0, 32'h0,  64'h0);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(0, 64'h0,   1, {32'hDEAD, 32'hBEEF},     1, 1, 0, 32'h0,  64'h0);
    tbl[15] = mk(0, 64'h0,    1, {32'hA1, 32'hA0},         1, 1, 0, 32'h0,  64'h0);
    tbl[16] = mk(0, 64'h0,    0, 64'h0,                    1, 0, 1, 32'hA0, 64'h2000);
    tbl[17] = mk(0, 64'h0,    0, 64'h0,                    0, 0, 1, 32'hA1, 64'h2004);
    tbl[18] = mk(1, 64'h4000, 1, {32'h77, 32'h66},         0, 0, 1, 32'hA1, 64'h2004);
    tbl[19] = mk(0, 64'h0,    0, 64'h0,                    0, 0, 0, 32'h0,  64'h0);

    for (int i = 0; i < 20; i++) begin
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      bus_respcyc = tbl[i].cyc;
      bus_resp    = tbl[i].resp;
      insn_ready  = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d ack", i),   64'(bus_respack), 64'(tbl[i].e_ack));
      chk($sformatf("row%0d valid", i), 64'(insn_valid),  64'(tbl[i].e_valid));
      chk($sformatf("row%0d insn", i),  64'(insn),        64'(tbl[i].e_insn));
      chk($sformatf("row%0d pc", i),    insn_pc,          tbl[i].e_pc);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
